// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Round-robin arbiter that shares one single-port RAM between three
// requesters: [0] io loader, [1] euler, [2] step.
//
// The grant is registered. It is held across beats while the owner keeps
// lock asserted. Holding is limited to MAX_BURST beats when another
// requester is waiting. A release and the next grant decision happen at
// the same edge, so there is no dead cycle between owners. Read data
// returns one cycle after the read address. rvalid is steered to the
// requester that issued the read, even if the grant has moved on by then.
//
// Ports
//   clk                 : single clock, rising edge
//   rst                 : asynchronous active-low reset
//   req/lock/wr [2:0]   : per-requester request, burst hold, direction (1=write)
//   addr0..2  [AW-1:0]  : per-requester RAM address
//   wdata0..2 [DW-1:0]  : per-requester write data
//   gnt        [2:0]    : registered one-hot (or zero) grant
//   owner      [1:0]    : granted requester index, 3 when idle
//   rvalid     [2:0]    : per-requester read-data-valid pulse
//   rdata      [DW-1:0] : read data (pass-through of ram_rdata)
//   ram_address/ram_WR_RD/ram_wdata : shared RAM request, zero when no beat
//   ram_rdata  [DW-1:0] : RAM read data, valid one cycle after a read address
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int DW        = 64,
    parameter int AW        = 64,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    lock,
    input  logic [2:0]    wr,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [1:0]    owner,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_address,
    output logic          ram_WR_RD,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [5:0] CNT_MAX = 6'(MAX_BURST - 1);
    localparam logic [1:0] IDLE_OWNER = 2'd3;

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t     r_state, w_nxt_state;
    logic [2:0] r_gnt, w_nxt_gnt;
    logic [1:0] r_owner, w_nxt_owner;
    logic [1:0] r_ptr, w_nxt_ptr;
    logic [5:0] r_beat_cnt, w_nxt_cnt;
    // Pending-read flags: one bit per requester whose read beat was last cycle.
    logic [2:0] r_rvalid, w_nxt_rvalid;

    // Per-requester views padded to 4 entries so that r_owner==3 (idle)
    // selects a harmless zero entry.
    logic [3:0]           w_req4, w_lock4, w_wr4;
    logic [3:0][AW-1:0]   w_addr;
    logic [3:0][DW-1:0]   w_wdata;

    logic       w_beat;
    logic       w_others;
    logic       w_release;
    logic       w_pick_vld;
    logic [1:0] w_pick_idx;

    assign w_req4  = {1'b0, req};
    assign w_lock4 = {1'b0, lock};
    assign w_wr4   = {1'b0, wr};

    assign w_addr[0]  = addr0;
    assign w_addr[1]  = addr1;
    assign w_addr[2]  = addr2;
    assign w_addr[3]  = '0;
    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;
    assign w_wdata[2] = wdata2;
    assign w_wdata[3] = '0;

    // Round-robin search starting just after the last granted requester.
    // The previous owner is tried last, so it is re-granted only when
    // nobody else is asking.
    always_comb begin
        logic [1:0] o0, o1, o2;
        case (r_ptr)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        w_pick_vld = 1'b1;
        w_pick_idx = IDLE_OWNER;
        if (w_req4[o0])      w_pick_idx = o0;
        else if (w_req4[o1]) w_pick_idx = o1;
        else if (w_req4[o2]) w_pick_idx = o2;
        else                 w_pick_vld = 1'b0;
    end

    assign w_beat    = (r_state == S_OWN) && w_req4[r_owner];
    assign w_others  = |(req & ~r_gnt);
    assign w_release = !w_req4[r_owner] || !w_lock4[r_owner]
                     || ((r_beat_cnt == CNT_MAX) && w_others);

    // Next-state / grant decision
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_owner = r_owner;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_nxt_state = S_OWN;
                    w_nxt_gnt   = 3'b001 << w_pick_idx;
                    w_nxt_owner = w_pick_idx;
                    w_nxt_ptr   = w_pick_idx;
                    w_nxt_cnt   = '0;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    // Every release starts a fresh grant, even when the
                    // same requester wins again, so the beat count restarts.
                    w_nxt_cnt = '0;
                    if (w_pick_vld) begin
                        w_nxt_gnt   = 3'b001 << w_pick_idx;
                        w_nxt_owner = w_pick_idx;
                        w_nxt_ptr   = w_pick_idx;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_gnt   = '0;
                        w_nxt_owner = IDLE_OWNER;
                    end
                end else if (r_beat_cnt != CNT_MAX) begin
                    // No release implies a beat. A lone owner saturates here.
                    w_nxt_cnt = r_beat_cnt + 6'd1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_gnt   = '0;
                w_nxt_owner = IDLE_OWNER;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Read return is tagged with the issuing requester, not the next owner.
    assign w_nxt_rvalid = (w_beat && !w_wr4[r_owner]) ? r_gnt : 3'b000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= IDLE_OWNER;
            r_ptr      <= 2'd2;
            r_beat_cnt <= '0;
            r_rvalid   <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_gnt      <= w_nxt_gnt;
            r_owner    <= w_nxt_owner;
            r_ptr      <= w_nxt_ptr;
            r_beat_cnt <= w_nxt_cnt;
            r_rvalid   <= w_nxt_rvalid;
        end
    end

    // RAM side is driven only during a beat. Reset forces IDLE
    // asynchronously, which zeroes these outputs at once.
    assign ram_WR_RD   = w_beat & w_wr4[r_owner];
    assign ram_address = w_beat ? w_addr[r_owner]  : '0;
    assign ram_wdata   = w_beat ? w_wdata[r_owner] : '0;

    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign rvalid = r_rvalid;
    assign rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MB = 4;

    logic          clk, rst;
    logic [2:0]    req, lock, wr;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] wdata0, wdata1, wdata2;
    logic [2:0]    gnt;
    logic [1:0]    owner;
    logic [2:0]    rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_address;
    logic          ram_WR_RD;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .wr(wr),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .owner(owner), .rvalid(rvalid), .rdata(rdata),
        .ram_address(ram_address), .ram_WR_RD(ram_WR_RD),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner index (-1 idle), last-granted pointer,
    // beats taken in the current grant, requester awaiting read data (-1 none).
    int m_own, m_ptr, m_cnt, m_pend;

    logic [2:0]    obs_gnt, obs_rv;
    logic [1:0]    obs_owner;
    logic          obs_wrrd;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (p + k) % 3;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_ptr = 2; m_cnt = 0; m_pend = -1;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs,
    // then advance the model across the rising edge.
    task automatic step(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w,
                        input logic [AW-1:0] x0, input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                        input logic [DW-1:0] y0, input logic [DW-1:0] y1, input logic [DW-1:0] y2,
                        input logic [DW-1:0] rd);
        logic [AW-1:0] aa [3];
        logic [DW-1:0] dd [3];
        logic [2:0]    eg, erv;
        logic [1:0]    eo;
        logic          ewr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            beat, oth, rel;
        int            nxt, npend;
        @(negedge clk);
        req = rq; lock = lk; wr = w;
        addr0 = x0; addr1 = x1; addr2 = x2;
        wdata0 = y0; wdata1 = y1; wdata2 = y2;
        ram_rdata = rd;
        #1;
        aa[0] = x0; aa[1] = x1; aa[2] = x2;
        dd[0] = y0; dd[1] = y1; dd[2] = y2;
        eg = 3'b000; eo = 2'd3; ewr = 1'b0; ea = '0; ed = '0; beat = 0;
        if (m_own >= 0) begin
            eg = 3'b001 << m_own;
            eo = 2'(m_own);
            beat = rq[m_own];
            if (beat) begin
                ewr = w[m_own];
                ea  = aa[m_own];
                ed  = dd[m_own];
            end
        end
        erv = (m_pend < 0) ? 3'b000 : (3'b001 << m_pend);
        obs_gnt = gnt; obs_owner = owner; obs_wrrd = ram_WR_RD;
        obs_addr = ram_address; obs_rv = rvalid; obs_rdata = rdata;
        chk("gnt",       64'(gnt),         64'(eg));
        chk("owner",     64'(owner),       64'(eo));
        chk("ram_WR_RD", 64'(ram_WR_RD),   64'(ewr));
        chk("ram_addr",  64'(ram_address), 64'(ea));
        chk("ram_wdata", 64'(ram_wdata),   64'(ed));
        chk("rvalid",    64'(rvalid),      64'(erv));
        chk("rdata",     64'(rdata),       64'(rd));
        @(posedge clk);
        npend = (beat && !w[m_own]) ? m_own : -1;
        if (m_own < 0) begin
            nxt = pick(rq, m_ptr);
            if (nxt >= 0) begin m_own = nxt; m_ptr = nxt; m_cnt = 0; end
        end else begin
            oth = (rq & ~(3'b001 << m_own)) != 3'b000;
            rel = !rq[m_own] || !lk[m_own] || (m_cnt == MB - 1 && oth);
            if (rel) begin
                nxt = pick(rq, m_ptr);
                m_own = nxt; m_cnt = 0;
                if (nxt >= 0) m_ptr = nxt;
            end else if (m_cnt < MB - 1) begin
                m_cnt++;
            end
        end
        m_pend = npend;
    endtask

    task automatic simple(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w,
                          input logic [DW-1:0] rd);
        step(rq, lk, w, AW'(0), AW'(1), AW'(2),
             DW'($urandom), DW'($urandom), DW'($urandom), rd);
    endtask

    initial begin
        logic [2:0]    exp_g [4];
        logic [AW-1:0] exp_a [4];
        rst = 1'b0; req = '0; lock = '0; wr = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0; ram_rdata = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst_gnt",   64'(gnt),         64'(3'b000));
        chk("rst_owner", 64'(owner),       64'(2'd3));
        chk("rst_wrrd",  64'(ram_WR_RD),   64'(1'b0));
        chk("rst_addr",  64'(ram_address), 64'(0));
        chk("rst_rv",    64'(rvalid),      64'(3'b000));
        @(negedge clk);
        rst = 1'b1;

        // Three-way write contention, no locks: 0,1,2,0
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_a[0] = AW'(0); exp_a[1] = AW'(1); exp_a[2] = AW'(2); exp_a[3] = AW'(0);
        simple(3'b111, 3'b000, 3'b111, DW'($urandom));
        chk("rr_first_idle", 64'(obs_gnt), 64'(3'b000));
        for (int i = 0; i < 4; i++) begin
            simple(3'b111, 3'b000, 3'b111, DW'($urandom));
            chk("rr_gnt",  64'(obs_gnt),  64'(exp_g[i]));
            chk("rr_addr", 64'(obs_addr), 64'(exp_a[i]));
            chk("rr_wrrd", 64'(obs_wrrd), 64'(1'b1));
        end
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));

        // Euler locked read burst, rvalid every cycle from the second beat
        for (int i = 0; i < 5; i++) begin
            step(3'b010, 3'b010, 3'b000, AW'(9), AW'(5), AW'(7),
                 DW'(0), DW'(0), DW'(0), DW'(32'hABCD));
            if (i >= 1) chk("burst_gnt", 64'(obs_gnt), 64'(3'b010));
            if (i >= 1) chk("burst_addr", 64'(obs_addr), 64'(5));
            if (i >= 2) chk("burst_rv", 64'(obs_rv), 64'(3'b010));
            if (i >= 2) chk("burst_rdata", 64'(obs_rdata), 64'(32'hABCD));
        end
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));

        // MAX_BURST cap: io joins at beat 1, euler finishes 4 beats, io follows
        for (int i = 0; i < 6; i++) begin
            simple((i >= 2 && i < 5) ? 3'b011 : ((i == 5) ? 3'b001 : 3'b010),
                   (i == 5) ? 3'b001 : 3'b010, 3'b011, DW'($urandom));
            if (i >= 1 && i <= 4) chk("cap_euler", 64'(obs_gnt), 64'(3'b010));
            if (i == 5) chk("cap_handoff", 64'(obs_gnt), 64'(3'b001));
        end
        // io owner drops req with nobody else waiting
        simple(3'b001, 3'b001, 3'b001, DW'($urandom));
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));
        chk("drop_wrrd", 64'(obs_wrrd), 64'(1'b0));
        chk("drop_addr", 64'(obs_addr), 64'(0));
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));
        chk("drop_idle", 64'(obs_gnt), 64'(3'b000));
        chk("drop_wrrd2", 64'(obs_wrrd), 64'(1'b0));

        // Read return follows the issuer across a grant change
        simple(3'b100, 3'b100, 3'b000, DW'($urandom));
        simple(3'b101, 3'b000, 3'b000, DW'($urandom));
        chk("xfer_step_gnt", 64'(obs_gnt), 64'(3'b100));
        simple(3'b001, 3'b000, 3'b001, DW'($urandom));
        chk("xfer_io_gnt", 64'(obs_gnt), 64'(3'b001));
        chk("xfer_rv", 64'(obs_rv), 64'(3'b100));
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));

        // Reset asserted mid read burst, between edges
        simple(3'b010, 3'b010, 3'b000, DW'($urandom));
        simple(3'b010, 3'b010, 3'b000, DW'($urandom));
        simple(3'b010, 3'b010, 3'b000, DW'($urandom));
        #2;
        rst = 1'b0; req = 3'b000; lock = 3'b000;
        #1;
        chk("mrst_gnt",   64'(gnt),       64'(3'b000));
        chk("mrst_owner", 64'(owner),     64'(2'd3));
        chk("mrst_wrrd",  64'(ram_WR_RD), 64'(1'b0));
        chk("mrst_rv",    64'(rvalid),    64'(3'b000));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        simple(3'b000, 3'b000, 3'b000, DW'($urandom));
        chk("mrst_no_rv", 64'(obs_rv), 64'(3'b000));
        // First grant after reset: simultaneous requests start at io
        simple(3'b110, 3'b000, 3'b000, DW'($urandom));
        simple(3'b111, 3'b000, 3'b000, DW'($urandom));
        chk("post_rst_gnt", 64'(obs_gnt), 64'(3'b010));

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(3'($urandom), 3'($urandom) | 3'($urandom), 3'($urandom),
                 AW'($urandom), AW'($urandom), AW'($urandom),
                 DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
